// File: rtl/muldiv_seq_if.sv
// -----------------------------------------------------------------------------
// muldiv_seq_if
// Handshake and operand bundle between the control unit / datapath and the
// sequential multiply/divide unit.
//   start  : launch request (master -> slave)
//   kill   : abort the operation in flight (master -> slave)
//   funct3 : RISC-V M-extension operation select (master -> slave)
//   op_w   : word-form select (master -> slave)
//   A, B   : rs1 / rs2 operands (master -> slave)
//   busy   : operation in flight (slave -> master)
//   done   : one-cycle result-valid pulse (slave -> master)
//   S      : result, held until the next accepted start (slave -> master)
// -----------------------------------------------------------------------------
interface muldiv_seq_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic            op_w;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] S;

    modport master (
        output start, kill, funct3, op_w, A, B,
        input  busy, done, S
    );

    modport slave (
        input  start, kill, funct3, op_w, A, B,
        output busy, done, S
    );
endinterface

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
// Multicycle RV32M/RV64M multiply/divide unit. Multiplies by shift-add into a
// double-width product register and divides by restoring shift-subtract, one
// iteration per clock. Signed operands are reduced to magnitudes at launch and
// the result sign is restored in the DONE state.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : muldiv_seq_if slave modport (start/kill/funct3/op_w/A/B in,
//           busy/done/S out; all outputs registered)
// The XLEN parameter must match the XLEN of the connected interface.
// -----------------------------------------------------------------------------
module muldiv_seq #(
    parameter int XLEN      = 64,
    parameter bit W_SUPPORT = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    muldiv_seq_if.slave bus
);
    // Word forms only exist on a 64-bit datapath.
    localparam bit W_EN = (XLEN == 64) && W_SUPPORT;
    localparam logic [6:0] N_FULL = 7'(XLEN);
    localparam logic [6:0] N_WORD = 7'd32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        logic [XLEN-1:0] r;
        r       = {XLEN{x[31]}};
        r[31:0] = x;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] x);
        logic [XLEN-1:0] r;
        r       = {XLEN{1'b0}};
        r[31:0] = x;
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [2:0]        fn_q, fn_d;
    logic              w_q, w_d;
    logic              qneg_q, qneg_d;   // negate product / quotient
    logic              rneg_q, rneg_d;   // negate remainder
    logic              fast_q, fast_d;   // acc_q already holds the final result
    logic [2*XLEN-1:0] acc_q, acc_d;     // product accumulator / fast result
    logic [2*XLEN-1:0] mcand_q, mcand_d; // multiplicand, shifted left per step
    logic [XLEN-1:0]   opb_q, opb_d;     // multiplier (shifted right) or divisor
    logic [XLEN-1:0]   quo_q, quo_d;     // dividend bits shifting out, quotient in
    logic [XLEN-1:0]   rem_q, rem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   s_q, s_d;

    // Launch-time operand decode
    logic              w_s;
    logic [2:0]        fn_s;
    logic              sgn_a_s, sgn_b_s, neg_a_s, neg_b_s;
    logic [XLEN-1:0]   a_ext_s, b_ext_s, a_mag_s, b_mag_s, a_res_s, min_n_s;
    logic              div_zero_s, div_ovf_s;

    // Iteration datapath and result correction
    logic [XLEN:0]     div_sh_s;
    logic [XLEN-1:0]   div_diff_s;
    logic              div_ge_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, raw_s, res_s;

    // Decode operation and operands presented on the bus for a possible launch.
    always_comb begin
        w_s  = W_EN && bus.op_w;
        // Illegal word-form multiplies (001..011) run as MULW.
        fn_s = (w_s && !bus.funct3[2]) ? 3'b000 : bus.funct3;
        case (fn_s)
            3'b000, 3'b001, 3'b100, 3'b110: begin sgn_a_s = 1'b1; sgn_b_s = 1'b1; end
            3'b010:                         begin sgn_a_s = 1'b1; sgn_b_s = 1'b0; end
            3'b011, 3'b101, 3'b111:         begin sgn_a_s = 1'b0; sgn_b_s = 1'b0; end
            default:                        begin sgn_a_s = 1'b0; sgn_b_s = 1'b0; end
        endcase
        if (w_s) begin
            a_ext_s = sgn_a_s ? sext32(bus.A[31:0]) : zext32(bus.A[31:0]);
            b_ext_s = sgn_b_s ? sext32(bus.B[31:0]) : zext32(bus.B[31:0]);
            a_res_s = sext32(bus.A[31:0]);
            min_n_s = sext32(32'h8000_0000);
        end else begin
            a_ext_s = bus.A;
            b_ext_s = bus.B;
            a_res_s = bus.A;
            min_n_s = {1'b1, {(XLEN-1){1'b0}}};
        end
        neg_a_s    = sgn_a_s && a_ext_s[XLEN-1];
        neg_b_s    = sgn_b_s && b_ext_s[XLEN-1];
        a_mag_s    = neg_a_s ? -a_ext_s : a_ext_s;
        b_mag_s    = neg_b_s ? -b_ext_s : b_ext_s;
        div_zero_s = fn_s[2] && (b_ext_s == {XLEN{1'b0}});
        div_ovf_s  = fn_s[2] && !fn_s[0] && (a_ext_s == min_n_s) && (b_ext_s == {XLEN{1'b1}});
    end

    // Restoring-division step and sign-corrected result selection.
    always_comb begin
        div_sh_s   = {rem_q, quo_q[XLEN-1]};
        div_ge_s   = (div_sh_s >= {1'b0, opb_q});
        // Only used when div_ge_s holds, so the difference fits in XLEN bits.
        div_diff_s = div_sh_s[XLEN-1:0] - opb_q;
        prod_s     = qneg_q ? -acc_q : acc_q;
        quo_s      = qneg_q ? -quo_q : quo_q;
        rem_s      = rneg_q ? -rem_q : rem_q;
        case (fn_q)
            3'b000:                 raw_s = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: raw_s = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         raw_s = quo_s;
            3'b110, 3'b111:         raw_s = rem_s;
            default:                raw_s = {XLEN{1'b0}};
        endcase
        if (fast_q) begin
            res_s = acc_q[XLEN-1:0];
        end else if (w_q) begin
            res_s = sext32(raw_s[31:0]);
        end else begin
            res_s = raw_s;
        end
    end

    // Next-state and datapath-update logic for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fn_d    = fn_q;
        w_d     = w_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        fast_d  = fast_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        opb_d   = opb_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        s_d     = s_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start && !bus.kill) begin
                    fn_d    = fn_s;
                    w_d     = w_s;
                    qneg_d  = neg_a_s ^ neg_b_s;
                    rneg_d  = neg_a_s;
                    cnt_d   = w_s ? N_WORD : N_FULL;
                    mcand_d = {{XLEN{1'b0}}, a_mag_s};
                    opb_d   = b_mag_s;
                    // Left-align a word dividend so its MSB is shifted out first.
                    quo_d   = w_s ? (a_mag_s << (XLEN - 32)) : a_mag_s;
                    rem_d   = {XLEN{1'b0}};
                    busy_d  = 1'b1;
                    if (div_zero_s || div_ovf_s) begin
                        fast_d  = 1'b1;
                        state_d = DONE;
                        if (fn_s[1]) begin
                            acc_d = div_zero_s ? {{XLEN{1'b0}}, a_res_s} : {(2*XLEN){1'b0}};
                        end else begin
                            acc_d = div_zero_s ? {{XLEN{1'b0}}, {XLEN{1'b1}}} : {{XLEN{1'b0}}, a_res_s};
                        end
                    end else begin
                        fast_d  = 1'b0;
                        state_d = CALC;
                        acc_d   = {(2*XLEN){1'b0}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (bus.kill) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 7'd1;
                    if (fn_q[2]) begin
                        if (div_ge_s) begin
                            rem_d = div_diff_s;
                            quo_d = {quo_q[XLEN-2:0], 1'b1};
                        end else begin
                            rem_d = div_sh_s[XLEN-1:0];
                            quo_d = {quo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        if (opb_q[0]) begin
                            acc_d = acc_q + mcand_q;
                        end else begin
                            acc_d = acc_q;
                        end
                        mcand_d = mcand_q << 1;
                        opb_d   = opb_q >> 1;
                    end
                    if (cnt_q == 7'd1) begin
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (bus.kill) begin
                    done_d = 1'b0;
                    s_d    = s_q;
                end else begin
                    done_d = 1'b1;
                    s_d    = res_s;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 7'd0;
            fn_q    <= 3'd0;
            w_q     <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            fast_q  <= 1'b0;
            acc_q   <= {(2*XLEN){1'b0}};
            mcand_q <= {(2*XLEN){1'b0}};
            opb_q   <= {XLEN{1'b0}};
            quo_q   <= {XLEN{1'b0}};
            rem_q   <= {XLEN{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= {XLEN{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fn_q    <= fn_d;
            w_q     <= w_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            fast_q  <= fast_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            opb_q   <= opb_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            s_q     <= s_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.S    = s_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
// Self-checking bench for muldiv_seq (XLEN=64, word forms enabled): a table of
// directed vectors, hand-written multi-cycle sequences (start while busy, kill
// in CALC and DONE, asynchronous reset mid-operation) and randomized operations
// compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;
    localparam int XLEN = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_seq_if #(.XLEN(XLEN)) bus_if ();

    muldiv_seq #(.XLEN(XLEN), .W_SUPPORT(1'b1)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        logic [2:0]  f;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_s;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [2:0] f, input logic w, input logic [63:0] a,
                                input logic [63:0] b, input logic [63:0] e, input int c);
        vec_t v;
        v.f = f; v.w = w; v.a = a; v.b = b; v.exp_s = e; v.exp_cyc = c;
        vecs.push_back(v);
    endfunction

    function automatic logic [63:0] sx32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    // Reference model: RISC-V M-extension semantics using the language's own arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] f, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] ps;
        logic [127:0]        pu;
        logic signed [63:0]  as64, bs64;
        logic signed [31:0]  as32, bs32;
        logic [31:0]         r32;
        logic [63:0]         r;
        as64 = a; bs64 = b; as32 = a[31:0]; bs32 = b[31:0];
        r = 64'd0; r32 = 32'd0;
        if (w) begin
            if (f == 3'b100) begin
                if (bs32 == 32'sd0) r32 = 32'hFFFF_FFFF;
                else if (as32 == 32'sh8000_0000 && bs32 == -32'sd1) r32 = as32;
                else r32 = as32 / bs32;
            end else if (f == 3'b101) begin
                if (b[31:0] == 32'd0) r32 = 32'hFFFF_FFFF;
                else r32 = a[31:0] / b[31:0];
            end else if (f == 3'b110) begin
                if (bs32 == 32'sd0) r32 = as32;
                else if (as32 == 32'sh8000_0000 && bs32 == -32'sd1) r32 = 32'd0;
                else r32 = as32 % bs32;
            end else if (f == 3'b111) begin
                if (b[31:0] == 32'd0) r32 = a[31:0];
                else r32 = a[31:0] % b[31:0];
            end else begin
                r32 = a[31:0] * b[31:0];
            end
            r = sx32(r32);
        end else begin
            case (f)
                3'b000: r = a * b;
                3'b001: begin ps = as64 * bs64; r = ps[127:64]; end
                3'b010: begin ps = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); r = ps[127:64]; end
                3'b011: begin pu = {64'd0, a} * {64'd0, b}; r = pu[127:64]; end
                3'b100: begin
                    if (b == 64'd0) r = '1;
                    else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
                    else r = as64 / bs64;
                end
                3'b101: begin if (b == 64'd0) r = '1; else r = a / b; end
                3'b110: begin
                    if (b == 64'd0) r = a;
                    else if (a == 64'h8000_0000_0000_0000 && b == '1) r = 64'd0;
                    else r = as64 % bs64;
                end
                3'b111: begin if (b == 64'd0) r = a; else r = a % b; end
                default: r = 64'd0;
            endcase
        end
        return r;
    endfunction

    // Cycles from the start cycle to the done cycle, inclusive.
    function automatic int exp_cycles(input logic [2:0] f, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
        logic fast;
        if (w) fast = f[2] && ((b[31:0] == 32'd0) ||
                      (!f[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF));
        else   fast = f[2] && ((b == 64'd0) ||
                      (!f[0] && a == 64'h8000_0000_0000_0000 && b == '1));
        if (fast) return 2;
        else if (w) return 34;
        else return 66;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'($urandom_range(0, 20));
            4:       return {32'hFFFF_FFFF, $urandom};
            5:       return 64'h0000_0000_8000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Launch one operation, scramble the inputs after capture, wait for done.
    task automatic run_op(input logic [2:0] f, input logic w, input logic [63:0] a,
                          input logic [63:0] b, output logic [63:0] s, output int cyc);
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.funct3 = f; bus_if.op_w = w; bus_if.A = a; bus_if.B = b;
        @(posedge clk); #1;
        bus_if.start  = 1'b0;
        bus_if.A      = {$urandom, $urandom};
        bus_if.B      = {$urandom, $urandom};
        bus_if.funct3 = 3'($urandom_range(0, 7));
        bus_if.op_w   = 1'($urandom_range(0, 1));
        check("busy_after_start", {63'd0, bus_if.busy}, 64'd1);
        cyc = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (bus_if.done) begin
                cyc = i + 1;
                break;
            end
        end
        s = bus_if.S;
        if (cyc > 0) check("busy_at_done", {63'd0, bus_if.busy}, 64'd0);
    endtask

    initial begin
        logic [63:0] s, last_s, exp_s, a, b;
        logic [2:0]  f;
        logic        w;
        int          cyc, exp_c, done_cnt, busy_cnt;

        bus_if.start = 1'b0; bus_if.kill = 1'b0; bus_if.funct3 = 3'd0;
        bus_if.op_w = 1'b0; bus_if.A = 64'd0; bus_if.B = 64'd0;

        //            f       w     A                        B                        expected S               cycles
        add(3'b000, 1'b0, 64'd7,                    -64'sd3,                 64'hFFFF_FFFF_FFFF_FFEB, 66);
        add(3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'd2,                    64'hFFFF_FFFF_FFFF_FFFF, 66);
        add(3'b011, 1'b0, 64'h8000_0000_0000_0000, 64'd2,                    64'h0000_0000_0000_0001, 66);
        add(3'b010, 1'b0, '1,                       64'd2,                    64'hFFFF_FFFF_FFFF_FFFF, 66);
        add(3'b100, 1'b0, -64'sd7,                  64'd2,                    64'hFFFF_FFFF_FFFF_FFFD, 66);
        add(3'b110, 1'b0, -64'sd7,                  64'd2,                    64'hFFFF_FFFF_FFFF_FFFF, 66);
        add(3'b101, 1'b0, 64'd7,                    64'd0,                    64'hFFFF_FFFF_FFFF_FFFF, 2);
        add(3'b110, 1'b0, 64'd5,                    64'd0,                    64'd5,                   2);
        add(3'b100, 1'b0, 64'h8000_0000_0000_0000, '1,                       64'h8000_0000_0000_0000, 2);
        add(3'b110, 1'b0, 64'h8000_0000_0000_0000, '1,                       64'd0,                   2);
        add(3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2);
        add(3'b000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2,                    64'hFFFF_FFFF_FFFF_FFFE, 34);
        add(3'b101, 1'b1, 64'hABCD_0000_8000_0000, 64'h1234_5678_0000_0001, 64'hFFFF_FFFF_8000_0000, 34);
        add(3'b111, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        add(3'b001, 1'b1, 64'd3,                    64'd5,                    64'd15,                  34);
        add(3'b110, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2,                    64'hFFFF_FFFF_FFFF_FFFF, 34);
        add(3'b101, 1'b0, 64'd100,                  64'd7,                    64'd14,                  66);
        add(3'b111, 1'b0, 64'd100,                  64'd7,                    64'd2,                   66);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, bus_if.busy}, 64'd0);
        check("reset_done", {63'd0, bus_if.done}, 64'd0);
        check("reset_S", bus_if.S, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table; consecutive launches also start in the cycle after done
        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].w, vecs[i].a, vecs[i].b, s, cyc);
            check($sformatf("vec%0d_S", i), s, vecs[i].exp_s);
            check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].exp_cyc));
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_pulse", i), {63'd0, bus_if.done}, 64'd0);
            check($sformatf("vec%0d_S_hold", i), bus_if.S, vecs[i].exp_s);
            last_s = vecs[i].exp_s;
        end

        // start pulsed at cycle 10 of an operation is ignored
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.funct3 = 3'b000; bus_if.op_w = 1'b0;
        bus_if.A = 64'd7; bus_if.B = -64'sd3;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        cyc = -1;
        for (int i = 1; i <= 200; i++) begin
            if (i == 10) begin
                @(negedge clk);
                bus_if.start = 1'b1; bus_if.funct3 = 3'b101; bus_if.A = 64'd100; bus_if.B = 64'd7;
            end
            @(posedge clk); #1;
            if (i == 10) bus_if.start = 1'b0;
            if (bus_if.done) begin
                cyc = i + 1;
                break;
            end
        end
        check("ignored_start_S", bus_if.S, 64'hFFFF_FFFF_FFFF_FFEB);
        check("ignored_start_cycles", 64'(cyc), 64'd66);
        last_s = 64'hFFFF_FFFF_FFFF_FFEB;
        busy_cnt = 0;
        repeat (5) begin
            @(posedge clk); #1;
            busy_cnt += int'(bus_if.busy);
        end
        check("ignored_start_not_queued", 64'(busy_cnt), 64'd0);

        // kill at CALC cycle 20
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.funct3 = 3'b000; bus_if.op_w = 1'b0;
        bus_if.A = 64'd123; bus_if.B = 64'd456;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        bus_if.kill = 1'b1;
        @(posedge clk); #1;
        bus_if.kill = 1'b0;
        check("kill_busy", {63'd0, bus_if.busy}, 64'd0);
        check("kill_done", {63'd0, bus_if.done}, 64'd0);
        check("kill_S", bus_if.S, last_s);
        done_cnt = 0; busy_cnt = 0;
        repeat (80) begin
            @(posedge clk); #1;
            done_cnt += int'(bus_if.done);
            busy_cnt += int'(bus_if.busy);
        end
        check("kill_no_done", 64'(done_cnt), 64'd0);
        check("kill_stays_idle", 64'(busy_cnt), 64'd0);

        // kill in DONE of a fast-path divide suppresses the result
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.funct3 = 3'b101; bus_if.op_w = 1'b0;
        bus_if.A = 64'd9; bus_if.B = 64'd0;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        @(negedge clk);
        bus_if.kill = 1'b1;
        @(posedge clk); #1;
        bus_if.kill = 1'b0;
        check("kill_done_state_done", {63'd0, bus_if.done}, 64'd0);
        check("kill_done_state_busy", {63'd0, bus_if.busy}, 64'd0);
        check("kill_done_state_S", bus_if.S, last_s);

        // Recovery after kill
        run_op(3'b101, 1'b0, 64'd100, 64'd7, s, cyc);
        check("post_kill_S", s, 64'd14);
        check("post_kill_cycles", 64'(cyc), 64'd66);

        // Asynchronous reset mid-CALC, checked before any further clock edge
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.funct3 = 3'b000; bus_if.op_w = 1'b0;
        bus_if.A = 64'd123; bus_if.B = 64'd456;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_busy", {63'd0, bus_if.busy}, 64'd0);
        check("async_reset_done", {63'd0, bus_if.done}, 64'd0);
        check("async_reset_S", bus_if.S, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'b011, 1'b0, 64'h8000_0000_0000_0000, 64'd2, s, cyc);
        check("post_reset_S", s, 64'd1);
        check("post_reset_cycles", 64'(cyc), 64'd66);

        // Randomized operations against the reference model
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            exp_s = ref_model(f, w, a, b);
            exp_c = exp_cycles(f, w, a, b);
            run_op(f, w, a, b, s, cyc);
            check($sformatf("rnd%0d_S f=%0d w=%0d a=%h b=%h", i, f, w, a, b), s, exp_s);
            check($sformatf("rnd%0d_cycles", i), 64'(cyc), 64'(exp_c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Parametrised multicycle integer multiply/divide unit implementing the RISC-V M extension (RV32M/RV64M, including W forms when XLEN=64).
- Sits beside the main ULA in the multicycle datapath. Operands come from Reg_A/Reg_B; the result is steered into the register-bank write mux.
- The control unit launches an operation with start, stalls on busy, and writes back on done.
- Replaces single-cycle combinational multiply with a shift-add/restoring-division engine sized by XLEN.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- W_SUPPORT, 1, enables the op_w word forms; forced to 0 when XLEN=32.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, launch request; sampled only when busy=0.
- kill, input, 1, synchronous abort of the operation in flight.
- funct3, input, 3, operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_w, input, 1, word form (MULW/DIVW/DIVUW/REMW/REMUW); only 000 and 1xx are legal with op_w=1.
- A, input, XLEN, rs1 operand (multiplicand/dividend).
- B, input, XLEN, rs2 operand (multiplier/divisor).
- busy, output, 1, operation in flight.
- done, output, 1, one-cycle pulse; result is valid.
- S, output, XLEN, result; held stable from done until the next accepted start.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, busy=0, done=0, S=0, all internal registers 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - On an edge with start=1, A, B, funct3 and op_w are captured.
  - Signed operands are converted to magnitudes and the result signs are recorded.
  - Iteration counter is loaded with N = op_w ? 32 : XLEN.
  - Next state is CALC, busy=1.
  - With op_w=1, operands are the low 32 bits, sign- or zero-extended per op.
- CALC:
  - One iteration per cycle: multiply uses shift-add into a 2N-bit product register; divide uses restoring shift-subtract with an N-bit remainder.
  - Counter decrements each cycle; after N CALC cycles the next state is DONE.
- DONE:
  - S is loaded with the sign-corrected result.
  - done=1 for exactly this cycle; busy drops to 0 on this cycle's edge.
  - Next state is IDLE.
- Latency: start accepted at edge k gives done high in the cycle following edge k+N+1, i.e. N+2 cycles from start to done (66 for XLEN=64, 34 for W forms and for XLEN=32).
- Result selection:
  - MUL: low N bits of the product.
  - MULH/MULHSU/MULHU: high N bits, with signed×signed, signed×unsigned and unsigned×unsigned respectively.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Remainder takes the sign of the dividend; quotient is negated when the operand signs differ (signed ops only).
  - W forms: the 32-bit result is sign-extended to XLEN, including DIVUW/REMUW.
- Fast paths (skip CALC; IDLE→DONE, done in the cycle after the capture edge):
  - Divisor zero: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - Signed overflow (dividend = most-negative N-bit value, divisor = -1): DIV = dividend, REM = 0.
- Handshake:
  - start while busy=1 is ignored; the unit does not queue.
  - start asserted in the same cycle as done is ignored; it is accepted on the next edge when busy=0.
  - Inputs A, B, funct3 and op_w need only be valid at the capture edge.
- kill:
  - kill=1 in CALC or DONE: next state IDLE, busy=0, done suppressed, S keeps its previous value.
  - kill has priority over start.
  - kill in IDLE has no effect.
- Reset mid-operation aborts immediately; outputs return to their reset values.
- Illegal funct3 with op_w=1 (001–011) is executed as MUL W form.

Test Plan:
- Reset with XLEN=64, then start MUL A=7, B=-3 → busy=1 next cycle, done exactly 66 cycles after start, S=0xFFFFFFFFFFFFFFEB.
- MULH A=0x8000000000000000, B=2 → S=0xFFFFFFFFFFFFFFFF. MULHU with the same operands → S=0x0000000000000001. MULHSU A=-1, B=2 → S=0xFFFFFFFFFFFFFFFF.
- DIV A=-7, B=2 → S=-3. REM with the same operands → S=-1. DIVU A=7, B=0 → done 2 cycles after start, S=all ones. REM A=5, B=0 → S=5.
- DIV A=0x8000000000000000, B=-1 → fast path, S=0x8000000000000000. REM with the same operands → S=0. DIVW A=0x80000000, B=0xFFFFFFFF → S=0xFFFFFFFF80000000.
- MULW A=0x7FFFFFFF, B=2 → done 34 cycles after start, S=0xFFFFFFFFFFFFFFFE. Pulse start at cycle 10 of an operation → ignored; the first result is unchanged.
- kill at CALC cycle 20 → busy=0 next cycle, no done, S unchanged. Assert reset low mid-CALC → busy=0, done=0 and S=0 immediately, without waiting for a clock edge.
